// File: rtl/risc16b_mem.sv
// risc16b_mem: unified instruction/data memory for risc16b with a byte-stream image loader
// that holds the CPU in reset until the image has been written.
module risc16b_mem #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_rdata,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_rdata,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_we,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        cpu_rst
);
  typedef enum logic [2:0] {ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, RUN} state_t;
  localparam int AW = ADDR_WIDTH;
  logic [15:0] mem [2**(AW-1)];
  state_t state, state_n;
  logic [15:0] ptr, cnt, w_data;
  logic [AW-2:0] w_idx;
  logic take, ld_wr, cpu_wr, wr_hi, wr_lo;
  logic unused;
  // Address bits outside the decoded window alias by design.
  assign unused = ^{i_addr, d_addr};
  assign i_rdata = i_oe ? mem[i_addr[AW-1:1]] : '0;
  assign d_rdata = d_oe ? mem[d_addr[AW-1:1]] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ADDR_H;
      ptr     <= '0;
      cnt     <= '0;
      cpu_rst <= 1'b1;
    end else begin
      state   <= state_n;
      cpu_rst <= state_n != RUN;
      if (take) begin
        case (state)
          ADDR_H:  ptr[15:8] <= ld_data;
          ADDR_L:  ptr[7:0]  <= ld_data;
          LEN_H:   cnt[15:8] <= ld_data;
          LEN_L:   cnt[7:0]  <= ld_data;
          DATA: begin
            ptr <= ptr + 16'd1;
            cnt <= cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end
  always_comb begin
    state_n = state;
    if (take) begin
      case (state)
        ADDR_H:  state_n = ADDR_L;
        ADDR_L:  state_n = LEN_H;
        LEN_H:   state_n = LEN_L;
        LEN_L:   state_n = ({cnt[15:8], ld_data} == 16'd0) ? RUN : DATA;
        DATA:    state_n = (cnt == 16'd1) ? RUN : DATA;
        default: state_n = RUN;
      endcase
    end
  end
  always_comb begin
    ld_ready = (state != RUN) && !rst;
    take     = ld_valid && ld_ready;
    ld_wr    = take && state == DATA;
    cpu_wr   = !cpu_rst;
  end
  // Loader and CPU writes are mutually exclusive through cpu_rst, so one write port suffices.
  always_comb begin
    w_idx  = ld_wr ? ptr[AW-1:1] : d_addr[AW-1:1];
    w_data = ld_wr ? {ld_data, ld_data} : d_wdata;
    wr_hi  = ld_wr ? !ptr[0] : cpu_wr && d_we[0];
    wr_lo  = ld_wr ? ptr[0] : cpu_wr && d_we[1];
  end
  always_ff @(posedge clk) begin
    if (wr_hi) mem[w_idx][15:8] <= w_data[15:8];
    if (wr_lo) mem[w_idx][7:0] <= w_data[7:0];
  end
endmodule
